transport_arbiter: RTL
======================

// Module: transport_arbiter
// PURPOSE
//   Grants one shared transport channel to two requesters, bus and train, so that
//   bus and train are never granted together while transport is active.
//   Ownership passes round-robin. Each lease is bounded and can be preempted.
//   A turnaround gap follows every release.
//   Sits between the bus/train request logic and the transport datapath enable.
// PARAMETERS
//   MAX_HOLD    16  max consecutive grant cycles while the other side is requesting (>=1)
//   GAP_CYCLES  1   idle cycles forced between any release and the next grant (>=1)
//   CNT_W       $clog2(MAX_HOLD+1)  hold counter width (derived, do not override)
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active-high
//   bus_req     in   1      bus requests transport; level, held until granted/done
//   train_req   in   1      train requests transport; level, held until granted/done
//   bus_done    in   1      bus releases; honoured only while bus_gnt=1
//   train_done  in   1      train releases; honoured only while train_gnt=1
//   bus_gnt     out  1      bus owns transport (registered)
//   train_gnt   out  1      train owns transport (registered)
//   transport   out  1      channel enable; always equal to bus_gnt|train_gnt
//   hold_cnt    out  CNT_W  cycles the current owner has held the channel (0 when idle)
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=IDLE, bus_gnt=0, train_gnt=0, transport=0, hold_cnt=0,
//     last_owner=TRAIN, so bus wins the first tie. Reset mid-grant drops all grants at that edge.
//   - States: IDLE, OWN_BUS, OWN_TRAIN, GAP.
//   - IDLE: requests are sampled at edge N; the grant is visible after edge N+1 (1-cycle latency).
//     Only bus_req -> OWN_BUS. Only train_req -> OWN_TRAIN.
//     Both -> the side that is not last_owner. Neither -> stay IDLE.
//   - OWN_x: x_gnt=1, transport=1, hold_cnt increments each cycle and saturates at MAX_HOLD.
//     Release when any of:
//     (a) x_done=1;
//     (b) x_req=0;
//     (c) hold_cnt==MAX_HOLD-1 and the other side is requesting (preempt).
//     On release: next state GAP, last_owner<=x, and gnt/transport/hold_cnt go to 0 at that edge.
//     Without contention the owner keeps the channel indefinitely; hold_cnt sits at MAX_HOLD.
//   - GAP: stay GAP_CYCLES cycles with all outputs 0, then arbitrate exactly as IDLE,
//     going directly to OWN_x or to IDLE. Requests raised during GAP are not lost.
//   - y_done with y not granted: ignored. done and req dropping together: a single release.
//   - Both req and done asserted by the owner in the same cycle: release wins. The owner
//     may re-win only if the other side is idle when GAP ends.
//   - Invariants, every cycle:
//     !(bus_gnt && train_gnt); transport==(bus_gnt||train_gnt);
//     transport |-> hold_cnt<=MAX_HOLD;
//     no grant in the GAP_CYCLES cycles after any release.
//   - Starvation bound: a held request is granted within MAX_HOLD+GAP_CYCLES+1 cycles.
// STRUCTURE
//   - transport_arb_pkg:
//       typedef enum logic [1:0] {IDLE, OWN_BUS, OWN_TRAIN, GAP} arb_state_t;
//       typedef enum logic {OWNER_BUS, OWNER_TRAIN} owner_t.
//   - One sub-module, transport_hold_timer: saturating up-counter with clear, enable and
//     an at_limit flag. It is instantiated twice: once for hold_cnt (limit MAX_HOLD-1)
//     and once for the GAP countdown (limit GAP_CYCLES-1).
//   - The FSM, last_owner register and registered outputs live in the top module.
// TESTING
//   1. rst 2 cycles, then bus_req=1 at 8ns -> bus_gnt=1, transport=1 one cycle later;
//      train_gnt stays 0.
//   2. bus_req=train_req=1 out of reset -> bus first. bus_done pulse -> 1 GAP cycle,
//      then train_gnt=1.
//   3. MAX_HOLD=4, bus holds with train_req=1 -> bus_gnt drops after 4 cycles
//      (hold_cnt 0..3), GAP 1 cycle, then train_gnt=1.
//   4. train_req=1 alone for 20 cycles -> train_gnt held throughout, hold_cnt saturates at 4,
//      no preemption.
//   5. rst=1 during OWN_TRAIN -> all outputs 0 at that edge. After release, bus is granted
//      before train on a tie.
//   6. Random req/done for 10k cycles; bind the SVA property
//      "transport throughout !(bus_gnt && train_gnt)" -> zero failures.

Source files
------------

// File: rtl/transport_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : transport_arb_pkg
// Purpose  : Shared types for the bus/train transport arbiter: the arbiter
//            state encoding and the identity of the most recent owner.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package transport_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OWN_BUS   = 2'd1,
    OWN_TRAIN = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_BUS   = 1'b0,
    OWNER_TRAIN = 1'b1
  } owner_t;

endpackage : transport_arb_pkg
`default_nettype wire

// File: rtl/transport_hold_timer.sv
`default_nettype none
// ============================================================================
// Module   : transport_hold_timer
// Purpose  : Saturating up-counter with synchronous clear and count enable,
//            plus a flag raised once the count has reached LIMIT.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous active-high reset
//            i_clear    - force the count to zero (has priority over enable)
//            i_enable   - advance the count by one, stopping at MAX_COUNT
//            o_count    - current count
//            o_at_limit - count >= LIMIT
// Revision : 1.0 - initial release
// ============================================================================
module transport_hold_timer #(
  parameter int WIDTH     = 4,
  parameter int LIMIT     = 3,
  parameter int MAX_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count,
  output logic             o_at_limit
);

  localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] c_MAX   = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != c_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The flag stays high once the count has passed LIMIT (it may saturate
  // above it), so a late-arriving competitor still sees the limit reached.
  generate
    if (LIMIT == 0) begin : g_limit_zero
      assign o_at_limit = 1'b1;
    end else begin : g_limit_cmp
      assign o_at_limit = (r_count >= c_LIMIT);
    end
  endgenerate

  assign o_count = r_count;

endmodule : transport_hold_timer
`default_nettype wire

// File: rtl/transport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : transport_arbiter
// Purpose  : Grants one shared transport channel to bus or train, never both.
//            Ownership alternates on ties, each lease is bounded by MAX_HOLD
//            when the other side is waiting, and every release is followed
//            by GAP_CYCLES idle cycles before the next grant.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            bus_req, train_req    - level requests
//            bus_done, train_done  - release strobes (only while granted)
//            bus_gnt, train_gnt    - registered grants
//            transport             - channel enable (bus_gnt | train_gnt)
//            hold_cnt              - cycles held by the current owner
// Revision : 1.0 - initial release
// ============================================================================
module transport_arbiter
  import transport_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_req,
  input  logic             train_req,
  input  logic             bus_done,
  input  logic             train_done,
  output logic             bus_gnt,
  output logic             train_gnt,
  output logic             transport,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);

  arb_state_t r_state;
  arb_state_t w_next_state;
  arb_state_t w_arb_choice;
  owner_t     r_last_owner;
  logic       r_bus_gnt;
  logic       r_train_gnt;

  logic               w_hold_clear;
  logic               w_hold_at_limit;
  logic               w_gap_clear;
  logic               w_gap_enable;
  logic               w_gap_at_limit;
  logic [c_GAP_W-1:0] w_unused_gap_cnt;

  // Arbitration used from IDLE and at the end of GAP; a tie goes to the side
  // that did not own the channel last.
  always_comb begin
    w_arb_choice = IDLE;
    if (bus_req && train_req) begin
      w_arb_choice = (r_last_owner == OWNER_TRAIN) ? OWN_BUS : OWN_TRAIN;
    end else if (bus_req) begin
      w_arb_choice = OWN_BUS;
    end else if (train_req) begin
      w_arb_choice = OWN_TRAIN;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        w_next_state = w_arb_choice;
      end
      OWN_BUS: begin
        if (bus_done || !bus_req || (w_hold_at_limit && train_req)) begin
          w_next_state = GAP;
        end
      end
      OWN_TRAIN: begin
        if (train_done || !train_req || (w_hold_at_limit && bus_req)) begin
          w_next_state = GAP;
        end
      end
      GAP: begin
        if (w_gap_at_limit) begin
          w_next_state = w_arb_choice;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_owner <= OWNER_TRAIN;
      r_bus_gnt    <= 1'b0;
      r_train_gnt  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_bus_gnt   <= (w_next_state == OWN_BUS);
      r_train_gnt <= (w_next_state == OWN_TRAIN);
      if ((r_state == OWN_BUS) && (w_next_state == GAP)) begin
        r_last_owner <= OWNER_BUS;
      end else if ((r_state == OWN_TRAIN) && (w_next_state == GAP)) begin
        r_last_owner <= OWNER_TRAIN;
      end
    end
  end

  // The hold counter only runs while the same owner keeps the channel, so
  // it reads zero on the first granted cycle and whenever nobody owns it.
  assign w_hold_clear = !(((r_state == OWN_BUS) || (r_state == OWN_TRAIN)) &&
                          (w_next_state == r_state));

  transport_hold_timer #(
    .WIDTH     (CNT_W),
    .LIMIT     (MAX_HOLD - 1),
    .MAX_COUNT (MAX_HOLD)
  ) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_hold_clear),
    .i_enable   (1'b1),
    .o_count    (hold_cnt),
    .o_at_limit (w_hold_at_limit)
  );

  // Counts cycles spent in GAP; arbitration resumes on the last of them.
  assign w_gap_clear  = (r_state != GAP);
  assign w_gap_enable = (r_state == GAP);

  transport_hold_timer #(
    .WIDTH     (c_GAP_W),
    .LIMIT     (GAP_CYCLES - 1),
    .MAX_COUNT (GAP_CYCLES - 1)
  ) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_gap_clear),
    .i_enable   (w_gap_enable),
    .o_count    (w_unused_gap_cnt),
    .o_at_limit (w_gap_at_limit)
  );

  assign bus_gnt   = r_bus_gnt;
  assign train_gnt = r_train_gnt;
  assign transport = r_bus_gnt | r_train_gnt;

endmodule : transport_arbiter
`default_nettype wire
